// File: rtl/led_stretch_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
// Fade/PWM stage is built only when LED_STRETCH_FADE_EN is defined.
package led_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FADE = 2'd2
  } state_e;

  function automatic int unsigned max_level(
    input int unsigned bits
  );
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic int unsigned cnt_width(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter and duty compare for the fade stage.
// Used by led_pulse_stretcher only when LED_STRETCH_FADE_EN is defined.
module led_pwm_gen
  import led_stretch_pkg::*;
#(
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] level_i,
  output logic                pwm_on_o
);

  logic [PWM_BITS-1:0] pwm_q;
  logic [PWM_BITS-1:0] pwm_d;

  assign pwm_d = pwm_q + PWM_BITS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  // Compared against next-cycle values so the registered led lines up.
  assign pwm_on_o = (pwm_d < level_i);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches short event pulses into a visible LED hold plus PWM fade.
// Define LED_STRETCH_FADE_EN to build the FADE stage; else hold-only.
module led_pulse_stretcher
  import led_stretch_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES      = 50000,
  parameter int unsigned FADE_STEP_CYCLES = 4096,
  parameter int unsigned PWM_BITS         = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig,
  output logic                led,
  output logic                busy,
  output logic [PWM_BITS-1:0] level
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (FADE_STEP_CYCLES < 1) begin : g_bad_step
    $error("FADE_STEP_CYCLES must be >= 1");
  end
  if (PWM_BITS < 1 || PWM_BITS > 8) begin : g_bad_bits
    $error("PWM_BITS must be 1..8");
  end

  localparam int unsigned HW = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX =
    PWM_BITS'(max_level(PWM_BITS));

  state_e              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q, led_d;
  logic                busy_q;

`ifdef LED_STRETCH_FADE_EN
  localparam int unsigned SW = cnt_width(FADE_STEP_CYCLES);
  localparam logic [SW-1:0] STEP_LAST = SW'(FADE_STEP_CYCLES - 1);

  logic [SW-1:0] step_q, step_d;
  logic          pwm_on;

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .level_i  (level_d),
    .pwm_on_o (pwm_on)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    step_d  = step_q;
    level_d = level_q;
    unique case (state_q)
      IDLE: begin
        level_d = '0;
        hold_d  = '0;
        step_d  = '0;
        if (trig) begin
          state_d = HOLD;
          level_d = LVL_MAX;
        end
      end
      HOLD: begin
        level_d = LVL_MAX;
        if (trig) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = FADE;
          hold_d  = '0;
          step_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      FADE: begin
        // A new event beats the pending step/decrement.
        if (trig) begin
          state_d = HOLD;
          level_d = LVL_MAX;
          hold_d  = '0;
          step_d  = '0;
        end else if (step_q == STEP_LAST) begin
          step_d  = '0;
          level_d = level_q - PWM_BITS'(1);
          if (level_q == PWM_BITS'(1)) begin
            state_d = IDLE;
          end
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        level_d = '0;
        hold_d  = '0;
        step_d  = '0;
      end
    endcase
    led_d = (state_d == HOLD) ||
            ((state_d == FADE) && pwm_on);
  end
`else
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    level_d = level_q;
    unique case (state_q)
      IDLE: begin
        level_d = '0;
        hold_d  = '0;
        if (trig) begin
          state_d = HOLD;
          level_d = LVL_MAX;
        end
      end
      HOLD: begin
        level_d = LVL_MAX;
        if (trig) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
          level_d = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        level_d = '0;
        hold_d  = '0;
      end
    endcase
    led_d = (state_d == HOLD);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      level_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      led_q   <= led_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign led   = led_q;
  assign busy  = busy_q;
  assign level = level_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Bench for led_pulse_stretcher: HOLD=4, STEP=2, PWM_BITS=2.
// Follows LED_STRETCH_FADE_EN the same way the RTL does.
module tb_led_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       trig2 = 1'b0;
  logic       led, busy, led2, busy2;
  logic [1:0] level, level2;

  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .HOLD_CYCLES      (4),
    .FADE_STEP_CYCLES (2),
    .PWM_BITS         (2)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .trig  (trig),
    .led   (led),
    .busy  (busy),
    .level (level)
  );

  led_pulse_stretcher #(
    .HOLD_CYCLES      (4),
    .FADE_STEP_CYCLES (4),
    .PWM_BITS         (2)
  ) u_duty (
    .clk   (clk),
    .rst   (rst),
    .trig  (trig2),
    .led   (led2),
    .busy  (busy2),
    .level (level2)
  );

  // md: 0 idle, 1 hold, 2 fade
  typedef struct {
    logic t;
    int   md;
    int   lv;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   pwm_m;

  always @(posedge clk or posedge rst) begin
    if (rst) pwm_m <= 0;
    else     pwm_m <= (pwm_m + 1) % 4;
  end

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic add(input logic t, input int md,
                     input int lv, input int n);
    vec_t v;
    v.t  = t;
    v.md = md;
    v.lv = lv;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic step(input logic t, input int md,
                      input int lv, input string nm);
    vec_t v;
    int   el;
    @(negedge clk);
    trig = t;
    v.t  = t;
    v.md = md;
    v.lv = lv;
    sb.push_back(v);
    @(posedge clk);
    #1;
    v  = sb.pop_front();
    el = (v.md == 1) ? 1 :
         (v.md == 2) ? int'(pwm_m < v.lv) : 0;
    check({nm, " busy"}, int'(busy), int'(v.md != 0));
    check({nm, " level"}, int'(level), v.lv);
    check({nm, " led"}, int'(led), el);
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      step(tbl[i].t, tbl[i].md, tbl[i].lv,
           $sformatf("%s[%0d]", nm, i));
    end
    tbl.delete();
  endtask

  task automatic async_rst(input string nm);
    @(negedge clk);
    #2 rst = 1'b1;
    trig = 1'b0;
    #1;
    check({nm, " led"}, int'(led), 0);
    check({nm, " busy"}, int'(busy), 0);
    check({nm, " level"}, int'(level), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset led", int'(led), 0);
    check("reset busy", int'(busy), 0);
    check("reset level", int'(level), 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef LED_STRETCH_FADE_EN
    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(0, 2, 3, 2); add(0, 2, 2, 2);
    add(0, 2, 1, 2); add(0, 0, 0, 2);
    run_tbl("pulse");

    add(1, 1, 3, 1); add(0, 1, 3, 1);
    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(0, 2, 3, 2); add(0, 2, 2, 1);
    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(0, 2, 3, 2); add(0, 2, 2, 2);
    add(0, 2, 1, 2); add(0, 0, 0, 1);
    run_tbl("retrig");

    begin
      int n2 = 0, on2 = 0, n1 = 0, on1 = 0;
      @(negedge clk);
      trig2 = 1'b1;
      @(negedge clk);
      trig2 = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (level2 == 2'd2 && busy2) begin
          n2++;
          on2 += int'(led2);
        end
        if (level2 == 2'd1 && busy2) begin
          n1++;
          on1 += int'(led2);
        end
        @(negedge clk);
      end
      check("duty lvl2 cycles", n2, 4);
      check("duty lvl2 on", on2, 2);
      check("duty lvl1 cycles", n1, 4);
      check("duty lvl1 on", on1, 1);
      check("duty done busy", int'(busy2), 0);
    end

    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(0, 2, 3, 2); add(0, 2, 2, 1);
    run_tbl("pre_rst");
    async_rst("rst_fade");
    add(0, 0, 0, 3);
    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(0, 2, 3, 1);
    run_tbl("post_rst");
`else
    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(0, 0, 0, 2);
    run_tbl("pulse");

    add(1, 1, 3, 1); add(0, 1, 3, 1);
    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(0, 0, 0, 1);
    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(0, 0, 0, 1);
    run_tbl("retrig");

    add(1, 1, 3, 1); add(0, 1, 3, 1);
    run_tbl("pre_rst");
    async_rst("rst_hold");
    add(0, 0, 0, 3);
    add(1, 1, 3, 1); add(0, 1, 3, 3);
    add(0, 0, 0, 1);
    run_tbl("post_rst");
`endif

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pulse_stretcher.md
Name: led_pulse_stretcher

Overview:
Output-side counterpart of the button-input conditioning. It takes a short hit/event pulse from game logic and drives a physical arrow LED. The LED is held on for a visible minimum time, then faded out with PWM. Short events become stable, human-visible output. One instance sits per arrow LED between the scoring logic and the board LED pins.

Parameters:
HOLD_CYCLES, 50000, clk cycles the LED is held fully on after a trigger (legal: >=1)
FADE_STEP_CYCLES, 4096, clk cycles spent at each brightness level during fade (legal: >=1)
PWM_BITS, 4, width of the brightness level and the PWM counter (legal: 1..8)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
trig  input  1  event request; any cycle it is high counts as a trigger (pulse or level)
led  output  1  LED drive, registered, glitch-free
busy  output  1  high while state != IDLE
level  output  PWM_BITS  current brightness; MAX = 2^PWM_BITS-1

Behaviour:
- Interface: one clock domain, clk. Reset rst is asynchronous and active-high. All outputs come straight from registers.
- Reset (async, any time, including mid-HOLD or mid-FADE):
  - state=IDLE; led=0; busy=0; level=0.
  - hold_cnt, step_cnt and pwm_cnt all 0.
  - No residual output after rst deasserts.
- pwm_cnt: free-running PWM_BITS counter; increments every cycle and wraps MAX->0 in all states.
- FSM states: IDLE, HOLD, FADE.
- IDLE:
  - trig=1 sampled at edge N -> HOLD, level=MAX, hold_cnt=0. led=1 from edge N onward (latency 1 cycle).
  - Otherwise stay in IDLE with led=0 and level=0.
- HOLD:
  - hold_cnt increments each cycle; led=1 constant.
  - When hold_cnt==HOLD_CYCLES-1 and trig=0 -> FADE, step_cnt=0, level stays MAX.
  - Retrigger: trig=1 in HOLD -> hold_cnt=0, stay in HOLD. Trig wins over expiry when both occur in the same cycle.
  - Held-high trig keeps the block in HOLD indefinitely.
- FADE:
  - step_cnt increments each cycle. When step_cnt==FADE_STEP_CYCLES-1: step_cnt=0 and level decrements by 1.
  - The decrement from 1 to 0 -> IDLE in the same edge.
  - trig=1 in FADE -> HOLD, level=MAX, hold_cnt=0. Trig has priority over the step/decrement.
  - FADE lasts exactly MAX*FADE_STEP_CYCLES cycles.
- led is a register loaded from next-state values:
  - led_next = (next_state==HOLD) | (next_state==FADE & pwm_next < level_next)
  - Duty cycle is level/2^PWM_BITS during FADE.
- busy is registered and equals (state != IDLE).
- Total on-time from a single 1-cycle trig = HOLD_CYCLES + MAX*FADE_STEP_CYCLES cycles.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No overflow is possible because each compare is to parameter-1.

Optional Feature:
LED_STRETCH_FADE_EN:
- Defined: behaviour as above (IDLE/HOLD/FADE).
- Undefined:
  - The FADE state, step_cnt and PWM compare are not compiled.
  - HOLD expiry goes directly to IDLE, and level=0 on the same edge.
  - level is MAX in HOLD and 0 otherwise; led = (state==HOLD).
  - busy high for exactly HOLD_CYCLES cycles per isolated trigger.

Decomposition:
- Package led_stretch_pkg:
  - state enum typedef (IDLE, HOLD, FADE), 2 bits.
  - Localparam helper for MAX level.
- One sub-module is natural: led_pwm_gen, holding the free-running pwm_cnt and the compare (level in, pwm_on out). It is compiled only with LED_STRETCH_FADE_EN.

Test Plan:
Bench parameters: HOLD_CYCLES=4, FADE_STEP_CYCLES=2, PWM_BITS=2 (MAX=3).
- Single pulse: trig high 1 cycle at edge 0 -> led=1 and busy=1 for cycles 1-4. Then FADE with level 3,3,2,2,1,1 over 6 cycles, then IDLE with level=0 and led=0. busy is high exactly 10 cycles.
- PWM duty: in FADE with level=2 over a 4-cycle window (FADE_STEP_CYCLES=4 variant) -> led high exactly 2 of 4 cycles. With level=1 -> 1 of 4.
- Retrigger: trig again 2 cycles into HOLD -> HOLD extends 4 cycles from the retrigger. Trig on the expiry edge -> stays in HOLD with hold_cnt=0.
- Trigger in FADE: trig while level=2 -> next cycle level=3, led=1, state HOLD, and a full fade sequence follows.
- Async reset mid-FADE: rst asserted between clock edges -> led=0, busy=0, level=0 immediately without a clock edge. After release, no output until the next trig.
- Macro off: same single pulse -> busy/led high cycles 1-4, level=3 during them, then 0. No FADE observed.
